// File: rtl/song_recorder.sv
// ---------------------------------------------------------------------------
// song_recorder
//   Turns live piano key presses into a stored score of (note, length)
//   entries. The score can then be replayed on the shared Buzzer note code
//   and the LEDs.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst_n      synchronous, active-low reset
//   mode       global mode selector (MODE_REC records, MODE_PLAY replays)
//   key        piano keys, bit0=do ... bit6=si
//   note       Buzzer note code: 0 = silent, 1..7 = do..si
//   led        one-hot LED of the sounding note, 0 when silent
//   rec_count  number of valid stored entries (0..DEPTH)
//   full       buffer full, held until the next recording starts
//   done       playback finished
// ---------------------------------------------------------------------------
module song_recorder #(
    parameter int         UNIT_CYCLES = 25_000_000,
    parameter int         DEPTH       = 64,
    parameter logic [2:0] MODE_REC    = 3'b101,
    parameter logic [2:0] MODE_PLAY   = 3'b110
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic [6:0] key,
    output logic [4:0] note,
    output logic [6:0] led,
    output logic [6:0] rec_count,
    output logic       full,
    output logic       done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(UNIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REC, PLAY, DONE} state_t;

    state_t          state_q;
    logic [4:0]      note_q;
    logic [6:0]      led_q;
    logic [6:0]      recCount_q;
    logic            full_q;
    logic            done_q;
    logic [2:0]      curCode_q;
    logic [CW-1:0]   cyc_q;
    logic [3:0]      len_q;
    logic [AW-1:0]   rdAddr_q;
    logic [6:0]      mem [DEPTH];

    logic [2:0]      keyCode;
    logic            keepEvent;
    logic            lastEntry;
    logic [AW-1:0]   rdNext;
    logic [6:0]      nextEntry;
    logic [6:0]      firstEntry;

    function automatic logic [6:0] ledOf(input logic [2:0] c);
        logic [6:0] r;
        r = 7'd0;
        if (c != 3'd0) r[c - 3'd1] = 1'b1;
        return r;
    endfunction

    // A chord or no key at all both count as a rest.
    always_comb begin
        keyCode = 3'd0;
        case (key)
            7'b0000001: keyCode = 3'd1;
            7'b0000010: keyCode = 3'd2;
            7'b0000100: keyCode = 3'd3;
            7'b0001000: keyCode = 3'd4;
            7'b0010000: keyCode = 3'd5;
            7'b0100000: keyCode = 3'd6;
            7'b1000000: keyCode = 3'd7;
            default:    keyCode = 3'd0;
        endcase
    end

    // While still recording, a rest is kept unless it leads the score;
    // when recording ends, the open rest is trailing and is always dropped.
    assign keepEvent = (len_q != 4'd0) && !full_q &&
                       ((curCode_q != 3'd0) ||
                        ((mode == MODE_REC) && (recCount_q != 7'd0)));

    assign lastEntry  = ((7'(rdAddr_q) + 7'd1) == recCount_q);
    assign rdNext     = rdAddr_q + AW'(1);
    assign nextEntry  = mem[rdNext];
    assign firstEntry = mem[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            note_q     <= 5'd0;
            led_q      <= 7'd0;
            recCount_q <= 7'd0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            curCode_q  <= 3'd0;
            cyc_q      <= '0;
            len_q      <= 4'd0;
            rdAddr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    note_q <= 5'd0;
                    led_q  <= 7'd0;
                    done_q <= 1'b0;
                    if (mode == MODE_REC) begin
                        state_q    <= REC;
                        recCount_q <= 7'd0;
                        full_q     <= 1'b0;
                        curCode_q  <= 3'd0;
                        cyc_q      <= '0;
                        len_q      <= 4'd0;
                    end else if (mode == MODE_PLAY) begin
                        state_q  <= PLAY;
                        rdAddr_q <= '0;
                        cyc_q    <= '0;
                        len_q    <= firstEntry[3:0];
                        if (recCount_q != 7'd0) begin
                            note_q <= {2'b00, firstEntry[6:4]};
                            led_q  <= ledOf(firstEntry[6:4]);
                        end
                    end
                end

                REC: begin
                    // An event closes either on a new key code or on leaving
                    // record mode; both cases share the same write path.
                    if (keepEvent && ((mode != MODE_REC) || (keyCode != curCode_q))) begin
                        mem[recCount_q[AW-1:0]] <= {curCode_q, len_q};
                        recCount_q <= recCount_q + 7'd1;
                        if (recCount_q == 7'(DEPTH - 1)) full_q <= 1'b1;
                    end
                    if (mode != MODE_REC) begin
                        state_q <= IDLE;
                        note_q  <= 5'd0;
                        led_q   <= 7'd0;
                    end else begin
                        note_q <= {2'b00, keyCode};
                        led_q  <= ledOf(keyCode);
                        if (keyCode != curCode_q) begin
                            // The closing cycle already belongs to the new
                            // event, so the cycle count restarts at one.
                            curCode_q <= keyCode;
                            cyc_q     <= (UNIT_CYCLES == 1) ? '0 : CW'(1);
                            len_q     <= (UNIT_CYCLES == 1) ? 4'd1 : 4'd0;
                        end else if (cyc_q == CW'(UNIT_CYCLES - 1)) begin
                            cyc_q <= '0;
                            if (len_q != 4'd15) len_q <= len_q + 4'd1;
                        end else begin
                            cyc_q <= cyc_q + CW'(1);
                        end
                    end
                end

                PLAY: begin
                    // len_q counts down whole units of the sounding entry and
                    // cyc_q counts cycles within the current unit.
                    if (mode != MODE_PLAY) begin
                        state_q <= IDLE;
                        note_q  <= 5'd0;
                        led_q   <= 7'd0;
                    end else if (recCount_q == 7'd0) begin
                        state_q <= DONE;
                        note_q  <= 5'd0;
                        led_q   <= 7'd0;
                        done_q  <= 1'b1;
                    end else if (cyc_q == CW'(UNIT_CYCLES - 1)) begin
                        cyc_q <= '0;
                        if (len_q <= 4'd1) begin
                            if (lastEntry) begin
                                state_q <= DONE;
                                note_q  <= 5'd0;
                                led_q   <= 7'd0;
                                done_q  <= 1'b1;
                            end else begin
                                rdAddr_q <= rdNext;
                                len_q    <= nextEntry[3:0];
                                note_q   <= {2'b00, nextEntry[6:4]};
                                led_q    <= ledOf(nextEntry[6:4]);
                            end
                        end else begin
                            len_q <= len_q - 4'd1;
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end

                DONE: begin
                    note_q <= 5'd0;
                    led_q  <= 7'd0;
                    if (mode != MODE_PLAY) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign note      = note_q;
    assign led       = led_q;
    assign rec_count = recCount_q;
    assign full      = full_q;
    assign done      = done_q;

endmodule
